// File: rtl/sq_out_normalizer.sv
// Carry-propagating normalizer: turns a redundant 17-bit-per-word square into a canonical integer.
// Optional upper-field-bit checking is enabled by defining SQ_NORM_FIELD_CHECK_EN.
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

module sq_out_normalizer #(
    parameter int MOD_LEN            = `MOD_LEN_DEF,
    parameter int WORD_LEN           = 16,
    parameter int REDUNDANT_ELEMENTS = 1,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int SQ_IN_BITS         = NUM_ELEMENTS * WORD_LEN * 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sq_valid,
    input  logic [SQ_IN_BITS-1:0]            sq_in,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
    output logic [1:0]                       carry_out,
    output logic                             done,
    output logic                             busy,
    output logic                             overrun,
    output logic                             field_err
);

    localparam int BIT_LEN = 17;
    localparam int SUM_W   = BIT_LEN + 1;
    localparam int FIELD_W = 2 * WORD_LEN;
    localparam int UPPER_W = FIELD_W - BIT_LEN;
    localparam int IDX_W   = $clog2(NUM_ELEMENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                            state_r;
    state_t                            state_s;
    logic                              capture_s;
    logic                              last_s;
    logic                              overrun_hit_s;
    logic [SUM_W-1:0]                  sum_s;
    logic [IDX_W-1:0]                  index_r;
    logic [1:0]                        carry_r;
    logic [1:0]                        carry_out_r;
    logic [NUM_ELEMENTS*WORD_LEN-1:0]  result_r;
    logic                              done_r;
    logic                              busy_r;
    logic                              overrun_r;
    logic [BIT_LEN-1:0]                coef_r [NUM_ELEMENTS];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s       = state_r;
        capture_s     = 1'b0;
        last_s        = 1'b0;
        overrun_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sq_valid) begin
                    state_s   = PROP;
                    capture_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            PROP: begin
                overrun_hit_s = sq_valid;
                if (index_r == LAST_IDX) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = PROP;
                end
            end
            DONE: begin
                if (sq_valid) begin
                    state_s   = PROP;
                    capture_s = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Carry never exceeds 2, so a 2-bit carry and an 18-bit sum always suffice.
    assign sum_s = SUM_W'(coef_r[index_r]) + SUM_W'(carry_r);

    // Coefficient capture; pure data storage, only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (capture_s && !reset) begin
            for (int j = 0; j < NUM_ELEMENTS; j++) begin
                coef_r[j] <= sq_in[j*FIELD_W +: BIT_LEN];
            end
        end
    end

    // Carry propagation datapath and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            index_r     <= '0;
            carry_r     <= 2'd0;
            carry_out_r <= 2'd0;
            result_r    <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            done_r <= (state_s == DONE);
            busy_r <= (state_s == PROP);
            if (overrun_hit_s) begin
                overrun_r <= 1'b1;
            end
            if (capture_s) begin
                index_r <= '0;
                carry_r <= 2'd0;
            end else if (state_r == PROP) begin
                result_r[index_r*WORD_LEN +: WORD_LEN] <= sum_s[WORD_LEN-1:0];
                carry_r <= sum_s[WORD_LEN +: 2];
                if (last_s) begin
                    carry_out_r <= sum_s[WORD_LEN +: 2];
                    index_r     <= '0;
                end else begin
                    index_r     <= index_r + IDX_W'(1);
                end
            end
        end
    end

`ifdef SQ_NORM_FIELD_CHECK_EN
    logic field_err_r;

    function automatic logic upper_bits_set(input logic [SQ_IN_BITS-1:0] v);
        logic acc;
        acc = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            acc = acc | (|v[j*FIELD_W+BIT_LEN +: UPPER_W]);
        end
        return acc;
    endfunction

    // Sticky flag for stray bits above the significant field, sampled at capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            field_err_r <= 1'b0;
        end else if (capture_s && upper_bits_set(sq_in)) begin
            field_err_r <= 1'b1;
        end
    end

    assign field_err = field_err_r;
`else
    logic unused_upper_s;
    assign unused_upper_s = ^sq_in;
    assign field_err      = 1'b0;
`endif

    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule
